// File: rtl/mem_arbiter.sv
// mem_arbiter: one shared bus between fetch and data ports, MEM priority with a fetch starvation guard
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_data_o,
    output logic                if_ack_o,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [DATA_W/8-1:0] mem_sel_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_ack_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_ack_i,
    output logic [5:0]          stall_o
);
    localparam int SEL_W = DATA_W / 8;
    typedef enum logic [2:0] {IDLE, BUS_IF, BUS_MEM, RESP_IF, RESP_MEM} state_t;
    state_t state_q, state_d;
    logic last_mem_q, last_mem_d;
    logic bus_we_q, bus_we_d;
    logic [SEL_W-1:0] bus_sel_q, bus_sel_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic grant_if, grant_mem, in_bus;
    always_comb begin
        grant_if = state_q == IDLE && if_req_i && (!mem_req_i || last_mem_q);
        grant_mem = state_q == IDLE && mem_req_i && !grant_if;
        in_bus = state_q == BUS_IF || state_q == BUS_MEM;
    end
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant_mem ? BUS_MEM : grant_if ? BUS_IF : IDLE;
            BUS_IF:  state_d = bus_ack_i ? RESP_IF : BUS_IF;
            BUS_MEM: state_d = bus_ack_i ? RESP_MEM : BUS_MEM;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        last_mem_d = (grant_if || grant_mem) ? grant_mem : last_mem_q;
        bus_we_d = grant_mem ? mem_we_i : grant_if ? 1'b0 : bus_we_q;
        bus_sel_d = grant_mem ? mem_sel_i : grant_if ? {SEL_W{1'b1}} : bus_sel_q;
        bus_addr_d = grant_mem ? mem_addr_i : grant_if ? if_addr_i : bus_addr_q;
        bus_wdata_d = grant_mem ? mem_wdata_i : grant_if ? '0 : bus_wdata_q;
        rdata_d = (in_bus && bus_ack_i) ? bus_rdata_i : rdata_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            last_mem_q <= 1'b0;
            bus_we_q <= 1'b0;
            bus_sel_q <= '0;
            bus_addr_q <= '0;
            bus_wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            last_mem_q <= last_mem_d;
            bus_we_q <= bus_we_d;
            bus_sel_q <= bus_sel_d;
            bus_addr_q <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q <= rdata_d;
        end
    end
    always_comb begin
        bus_req_o = in_bus;
        if_ack_o = state_q == RESP_IF;
        mem_ack_o = state_q == RESP_MEM;
        stall_o = (mem_req_i && !mem_ack_o) ? 6'b011111 :
                  (if_req_i && !if_ack_o) ? 6'b000111 : 6'b000000;
    end
    assign bus_we_o = bus_we_q;
    assign bus_sel_o = bus_sel_q;
    assign bus_addr_o = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign if_data_o = rdata_q;
    assign mem_rdata_o = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic [5:0]  stall_o;
    int vectors = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic req, input logic we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata);
        chk({tag, " bus_req"}, 64'(bus_req_o), 64'(req));
        chk({tag, " bus_we"}, 64'(bus_we_o), 64'(we));
        chk({tag, " bus_sel"}, 64'(bus_sel_o), 64'(sel));
        chk({tag, " bus_addr"}, 64'(bus_addr_o), 64'(addr));
        chk({tag, " bus_wdata"}, 64'(bus_wdata_o), 64'(wdata));
    endtask

    initial begin
        rst = 1'b1;
        if_req_i = 1'b0;
        mem_req_i = 1'b0;
        if_addr_i = $urandom;
        mem_we_i = 1'b1;
        mem_sel_i = 4'(($urandom));
        mem_addr_i = $urandom;
        mem_wdata_i = $urandom;
        bus_rdata_i = $urandom;
        bus_ack_i = 1'b1;
        // reset held two cycles with noisy non-request inputs
        tick();
        #1;
        chk("rst1 bus_req", 64'(bus_req_o), 64'd0);
        chk("rst1 if_ack", 64'(if_ack_o), 64'd0);
        chk("rst1 mem_ack", 64'(mem_ack_o), 64'd0);
        chk("rst1 stall", 64'(stall_o), 64'd0);
        if_addr_i = $urandom;
        bus_rdata_i = $urandom;
        tick();
        rst = 1'b0;
        bus_ack_i = 1'b0;
        #1;
        chk_bus("rst2", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("rst2 if_data", 64'(if_data_o), 64'd0);
        chk("rst2 mem_rdata", 64'(mem_rdata_o), 64'd0);
        tick();
        #1;
        chk("post_rst bus_req", 64'(bus_req_o), 64'd0);
        chk("post_rst acks", 64'({if_ack_o, mem_ack_o}), 64'd0);
        chk("post_rst stall", 64'(stall_o), 64'd0);

        // store with wait states: ack at cycle 4, mem_ack at cycle 5
        mem_req_i = 1'b1;
        mem_we_i = 1'b1;
        mem_sel_i = 4'b0011;
        mem_addr_i = 32'h2000;
        mem_wdata_i = 32'hDEADBEEF;
        #1;
        chk("st c0 stall", 64'(stall_o), 64'h1F);
        chk("st c0 bus_req", 64'(bus_req_o), 64'd0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 4) begin
                bus_ack_i = 1'b1;
                bus_rdata_i = 32'h12345678;
            end
            #1;
            chk_bus($sformatf("st c%0d", c), 1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF);
            chk($sformatf("st c%0d stall", c), 64'(stall_o), 64'h1F);
            chk($sformatf("st c%0d mem_ack", c), 64'(mem_ack_o), 64'd0);
        end
        tick();
        bus_ack_i = 1'b0;
        #1;
        chk("st c5 mem_ack", 64'(mem_ack_o), 64'd1);
        chk("st c5 mem_rdata", 64'(mem_rdata_o), 64'h12345678);
        chk("st c5 bus_req", 64'(bus_req_o), 64'd0);
        chk("st c5 stall", 64'(stall_o), 64'd0);
        tick();
        mem_req_i = 1'b0;
        #1;
        chk("st c6 mem_ack", 64'(mem_ack_o), 64'd0);

        // single fetch, request kept high through RESP_IF
        if_req_i = 1'b1;
        if_addr_i = 32'h100;
        #1;
        chk("if c0 stall", 64'(stall_o), 64'h07);
        tick();
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'h00A00093;
        #1;
        chk_bus("if c1", 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        chk("if c1 stall", 64'(stall_o), 64'h07);
        chk("if c1 if_ack", 64'(if_ack_o), 64'd0);
        tick();
        bus_ack_i = 1'b0;
        #1;
        chk("if c2 if_ack", 64'(if_ack_o), 64'd1);
        chk("if c2 if_data", 64'(if_data_o), 64'h00A00093);
        chk("if c2 bus_req", 64'(bus_req_o), 64'd0);
        chk("if c2 stall", 64'(stall_o), 64'd0);
        tick();
        if_req_i = 1'b0;
        #1;
        chk("if c3 bus_req", 64'(bus_req_o), 64'd0);
        chk("if c3 if_ack", 64'(if_ack_o), 64'd0);
        tick();
        #1;
        chk("if c4 no regrant", 64'(bus_req_o), 64'd0);

        // simultaneous requests: MEM first, then IF despite a fresh MEM request
        if_req_i = 1'b1;
        if_addr_i = 32'h104;
        mem_req_i = 1'b1;
        mem_we_i = 1'b0;
        mem_sel_i = 4'hF;
        mem_addr_i = 32'h3000;
        mem_wdata_i = 32'h0;
        #1;
        chk("sim c0 stall", 64'(stall_o), 64'h1F);
        tick();
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'hCAFE0001;
        #1;
        chk_bus("sim c1", 1'b1, 1'b0, 4'hF, 32'h3000, 32'h0);
        tick();
        bus_ack_i = 1'b0;
        #1;
        chk("sim c2 mem_ack", 64'(mem_ack_o), 64'd1);
        chk("sim c2 mem_rdata", 64'(mem_rdata_o), 64'hCAFE0001);
        chk("sim c2 if_ack", 64'(if_ack_o), 64'd0);
        chk("sim c2 stall", 64'(stall_o), 64'h07);
        tick();
        mem_we_i = 1'b1;
        mem_sel_i = 4'b1100;
        mem_addr_i = 32'h3004;
        mem_wdata_i = 32'h55AA55AA;
        #1;
        chk("sim c3 bus_req", 64'(bus_req_o), 64'd0);
        chk("sim c3 stall", 64'(stall_o), 64'h1F);
        tick();
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'h00000013;
        #1;
        chk_bus("sim c4 if wins", 1'b1, 1'b0, 4'hF, 32'h104, 32'h0);
        tick();
        bus_ack_i = 1'b0;
        #1;
        chk("sim c5 if_ack", 64'(if_ack_o), 64'd1);
        chk("sim c5 if_data", 64'(if_data_o), 64'h00000013);
        chk("sim c5 stall", 64'(stall_o), 64'h1F);
        tick();
        if_req_i = 1'b0;
        #1;
        chk("sim c6 bus_req", 64'(bus_req_o), 64'd0);
        tick();
        #1;
        chk_bus("sim c7", 1'b1, 1'b1, 4'b1100, 32'h3004, 32'h55AA55AA);

        // reset while in BUS_MEM, then a late bus ack
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_req_i = 1'b0;
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'hBADBAD00;
        #1;
        chk_bus("mrst c8", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("mrst c8 mem_ack", 64'(mem_ack_o), 64'd0);
        chk("mrst c8 stall", 64'(stall_o), 64'd0);
        tick();
        bus_ack_i = 1'b0;
        #1;
        chk("mrst c9 mem_ack", 64'(mem_ack_o), 64'd0);
        chk("mrst c9 bus_req", 64'(bus_req_o), 64'd0);
        chk("mrst c9 mem_rdata", 64'(mem_rdata_o), 64'd0);
        tick();
        #1;
        chk("mrst c10 acks", 64'({if_ack_o, mem_ack_o}), 64'd0);
        chk("mrst c10 bus_req", 64'(bus_req_o), 64'd0);

        // last_mem cleared by reset, so MEM wins a tie again
        if_req_i = 1'b1;
        if_addr_i = 32'h200;
        mem_req_i = 1'b1;
        mem_we_i = 1'b0;
        mem_sel_i = 4'hF;
        mem_addr_i = 32'h4000;
        mem_wdata_i = 32'h0;
        tick();
        #1;
        chk_bus("tie", 1'b1, 1'b0, 4'hF, 32'h4000, 32'h0);
        if_req_i = 1'b0;
        mem_req_i = 1'b0;
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        #1;
        chk("tie mem_ack", 64'(mem_ack_o), 64'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single shared memory bus between the instruction-fetch port (driven by the PC/IF stage) and the data-access port (driven by the MEM stage) of the 5-stage RISC-V core. It sequences one bus transaction at a time through a small FSM, returns read data and a one-cycle acknowledge to the winning client, and drives the pipeline stall vector while a client waits. It sits between the core top level and the external memory bus, replacing the direct ROM connection.

## Interface

- Parameters:
  - `ADDR_W`, default 32: bus and client address width.
  - `DATA_W`, default 32: data width; byte selects are `DATA_W/8` wide.
- Clock is `clk` and reset is `rst`; one clock; `rst` is synchronous and active-high.
- Ports:
  - `clk`, input, 1: clock, all state updates on the rising edge.
  - `rst`, input, 1: synchronous active-high reset.
  - `if_req_i`, input, 1: fetch request; held high until `if_ack_o`.
  - `if_addr_i`, input, ADDR_W: fetch address.
  - `if_data_o`, output, DATA_W: fetched instruction; valid only while `if_ack_o` is high.
  - `if_ack_o`, output, 1: one-cycle fetch completion pulse.
  - `mem_req_i`, input, 1: data request; held high until `mem_ack_o`.
  - `mem_we_i`, input, 1: 1 = store, 0 = load.
  - `mem_sel_i`, input, DATA_W/8: byte enables.
  - `mem_addr_i`, input, ADDR_W: data address.
  - `mem_wdata_i`, input, DATA_W: store data.
  - `mem_rdata_o`, output, DATA_W: load data; valid only while `mem_ack_o` is high.
  - `mem_ack_o`, output, 1: one-cycle data completion pulse.
  - `bus_req_o`, output, 1: bus cycle active.
  - `bus_we_o`, output, 1: bus write enable.
  - `bus_sel_o`, output, DATA_W/8: bus byte enables.
  - `bus_addr_o`, output, ADDR_W: bus address.
  - `bus_wdata_o`, output, DATA_W: bus write data.
  - `bus_rdata_i`, input, DATA_W: bus read data, sampled when `bus_ack_i` is high.
  - `bus_ack_i`, input, 1: bus completion.
  - `stall_o`, output, 6: pipeline stall vector. Bit 0 = pc, 1 = if, 2 = id, 3 = ex, 4 = mem, 5 = wb.

## Operation

- FSM states: `IDLE`, `BUS_IF`, `BUS_MEM`, `RESP_IF`, `RESP_MEM`.
- `IDLE`:
  - Grant the winner. The latched request fields are address, we, sel and wdata.
  - For a fetch, `bus_we_o` is 0 and `bus_sel_o` is all ones.
  - Next state is `BUS_IF` or `BUS_MEM`. With no request, stay in `IDLE`.
- Priority:
  - MEM wins over IF.
  - Exception: when the last served client was MEM and `if_req_i` is high, IF wins. This prevents fetch starvation.
  - `last_mem` flag resets to 0.
- `BUS_*`:
  - `bus_req_o` = 1, with all bus fields held stable from registers.
  - When `bus_ack_i` = 1, capture `bus_rdata_i` into the response register and go to `RESP_*`.
  - Otherwise wait indefinitely; there is no timeout.
- `RESP_IF` / `RESP_MEM`:
  - `bus_req_o` = 0.
  - The matching `*_ack_o` = 1 for exactly this cycle, with the captured data on `*_data_o`/`*_rdata_o`.
  - Next state is always `IDLE`. A request still high in this cycle counts as already served and is not re-granted.
- `mem_rdata_o` is driven with the captured value on stores too; the client ignores it.
- Stall vector (combinational from requests and acks):
  - If `mem_req_i && !mem_ack_o`: `stall_o` = 6'b011111.
  - Else if `if_req_i && !if_ack_o`: `stall_o` = 6'b000111.
  - Else `stall_o` = 0.
- Client inputs are sampled only in `IDLE`. Changes while a request is pending are a protocol violation; behaviour is unspecified.
- Reset mid-transaction: on the next edge go to `IDLE` with all outputs at reset values. An in-flight bus cycle is abandoned, and a late `bus_ack_i` is ignored.

## Timing

- Reset values:
  - State `IDLE`.
  - `bus_req_o`, `bus_we_o` = 0.
  - `bus_sel_o`, `bus_addr_o`, `bus_wdata_o` = 0.
  - `if_ack_o`, `mem_ack_o` = 0.
  - `if_data_o`, `mem_rdata_o` = 0.
  - `last_mem` = 0.
  - `stall_o` follows its equation; it is 0 with no requests.
- Latency:
  - Request first seen in `IDLE` at cycle 0.
  - `bus_req_o` is high from cycle 1.
  - `bus_ack_i` arrives at cycle k ≥ 1.
  - `*_ack_o` is high at cycle k+1.
  - `IDLE` again at cycle k+2.
  - Minimum is 2 cycles request-to-ack, with a zero-wait bus.
- Throughput: at most one transaction per 3 cycles.
- `bus_ack_i` is ignored in every state other than `BUS_*`.
- All bus and client outputs are registered; only `stall_o` is combinational.

## Test plan

1. **Reset.** Hold `rst` 2 cycles with random inputs, then release.
   - During reset and after release: `bus_req_o` = 0, both acks 0, `stall_o` = 0.
2. **Single fetch.** `if_req_i`=1, `if_addr_i`=0x100. Bus acks at cycle 1 with 0x00A00093.
   - `bus_addr_o`=0x100, `bus_sel_o`=4'hF, `bus_we_o`=0.
   - `if_ack_o`=1 at cycle 2 with `if_data_o`=0x00A00093.
   - `stall_o`=6'b000111 for cycles 0–1.
3. **Store with wait states.** `mem_req_i`=1, `mem_we_i`=1, `mem_sel_i`=4'b0011, addr 0x2000, wdata 0xDEADBEEF. Bus ack delayed to cycle 4.
   - Bus fields are stable for cycles 1–4.
   - `mem_ack_o` pulses at cycle 5.
   - `stall_o`=6'b011111 for cycles 0–4.
4. **Simultaneous requests.** IF (0x104) and MEM load (0x3000) both raised at cycle 0.
   - MEM is served first.
   - IF is granted at the next `IDLE`, even though a new MEM request is present then (starvation guard).
   - `stall_o` shows 6'b011111, then 6'b000111.
5. **No double grant.** Keep `if_req_i` high through the `RESP_IF` cycle.
   - Exactly one bus cycle occurs per request.
   - A new grant happens only from the following `IDLE`.
6. **Reset mid-transaction.** Assert `rst` in `BUS_MEM`, then drive a late `bus_ack_i`.
   - `bus_req_o` = 0 next edge.
   - No `mem_ack_o` pulse.
   - FSM stays in `IDLE`.
